// File: rtl/nr_bit_arb.sv
// nr_bit_arb: two-requester round-robin arbiter in front of a shared
// bit-compact / bit-extend unit with a registered result and sticky zero flag.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req0/req1            requests, held until the matching done pulse
//   op0/op1              0 = OR-reduce data to 1 bit, 1 = zero-extend data[3:0]
//   data0/data1          8-bit operands
//   gnt0/gnt1            high while the unit serves that requester (EXEC, RESP)
//   done0/done1          one-cycle completion pulse, res valid alongside
//   res                  result register
//   zflag                sticky zero flag, written by compact ops only
//   busy                 high whenever the FSM is not idle
module nr_bit_arb #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       op0,
    input  logic       op1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] res,
    output logic       zflag,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       sel_q, sel_d;
    logic       op_q, op_d;
    logic [7:0] data_q, data_d;
    logic [7:0] res_q, res_d;
    logic       zflag_q, zflag_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       pick;

    // Both requesting: the pointer holder wins; otherwise whoever asks.
    assign pick = (req0 && req1) ? ptr_q : req1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req0 || req1) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != IDLE);
        gnt0 = busy && !sel_q;
        gnt1 = busy && sel_q;
    end

    // Datapath and bookkeeping
    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        op_d    = op_q;
        data_d  = data_q;
        res_d   = res_q;
        zflag_d = zflag_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d  = pick;
                    op_d   = pick ? op1 : op0;
                    data_d = pick ? data1 : data0;
                end
            end
            EXEC: begin
                if (op_q) begin
                    res_d = {4'b0000, data_q[3:0]};
                end else begin
                    res_d   = {7'b0, |data_q};
                    zflag_d = ~|data_q;
                end
            end
            RESP: begin
                // Completion is registered, so the pulse lands the cycle
                // after RESP, two edges after the grant.
                ptr_d   = ~sel_q;
                done0_d = ~sel_q;
                done1_d = sel_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= PRIO_INIT;
            sel_q   <= 1'b0;
            op_q    <= 1'b0;
            data_q  <= 8'h00;
            res_q   <= 8'h00;
            zflag_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            data_q  <= data_d;
            res_q   <= res_d;
            zflag_q <= zflag_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign done0 = done0_q;
    assign done1 = done1_q;
    assign res   = res_q;
    assign zflag = zflag_q;

endmodule

// File: tb/tb_nr_bit_arb.sv
// tb_nr_bit_arb: directed bench for nr_bit_arb with a transaction-level
// reference model compared every cycle plus literal spot checks.
module tb_nr_bit_arb;

    localparam bit P = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       op0 = 1'b0, op1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       gnt0, gnt1, done0, done1, zflag, busy;
    logic [7:0] res;

    int total = 0;
    int bad = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    nr_bit_arb #(.PRIO_INIT(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .res(res), .zflag(zflag), .busy(busy)
    );

    // Reference model: phase 0 idle, 1 computing, 2 responding.
    int         m_phase = 0;
    bit         m_srv = 1'b0, m_ptr = P, m_op = 1'b0;
    logic [7:0] m_dat = 8'h00, m_res = 8'h00;
    bit         m_z = 1'b0, m_d0 = 1'b0, m_d1 = 1'b0;
    bit         m_pick;

    assign m_pick = (req0 && req1) ? m_ptr : req1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_srv <= 1'b0; m_ptr <= P; m_op <= 1'b0;
            m_dat <= 8'h00; m_res <= 8'h00; m_z <= 1'b0;
            m_d0 <= 1'b0; m_d1 <= 1'b0;
        end else begin
            m_d0 <= 1'b0;
            m_d1 <= 1'b0;
            if (m_phase == 0) begin
                if (req0 || req1) begin
                    m_srv <= m_pick;
                    m_op <= m_pick ? op1 : op0;
                    m_dat <= m_pick ? data1 : data0;
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (m_op) begin
                    m_res <= 8'(m_dat % 16);
                end else begin
                    m_res <= (m_dat != 0) ? 8'd1 : 8'd0;
                    m_z <= (m_dat == 0);
                end
                m_phase <= 2;
            end else begin
                if (m_srv) m_d1 <= 1'b1;
                else m_d0 <= 1'b1;
                m_ptr <= !m_srv;
                m_phase <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("m_gnt0", {7'b0, gnt0}, {7'b0, (m_phase != 0) && !m_srv});
            chk("m_gnt1", {7'b0, gnt1}, {7'b0, (m_phase != 0) && m_srv});
            chk("m_done0", {7'b0, done0}, {7'b0, m_d0});
            chk("m_done1", {7'b0, done1}, {7'b0, m_d1});
            chk("m_busy", {7'b0, busy}, {7'b0, m_phase != 0});
            chk("m_res", res, m_res);
            chk("m_zflag", {7'b0, zflag}, {7'b0, m_z});
        end
    end

    task automatic wait_done(input bit who, input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = who ? done1 : done0;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s done timeout got=0 want=1", nm);
        end
    endtask

    task automatic wait_any(output bit who, output logic [7:0] r);
        bit seen;
        seen = 1'b0;
        who = 1'b0;
        r = 8'hxx;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (done0 || done1) begin
                seen = 1'b1;
                who = done1;
                r = res;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rr_wait timeout got=0 want=1");
        end
    endtask

    logic [7:0] exp_res [3];
    bit         exp_who [3];

    initial begin
        bit         w;
        logic [7:0] r;
        exp_res[0] = 8'h01; exp_res[1] = 8'h0C; exp_res[2] = 8'h01;
        exp_who[0] = 1'b0;  exp_who[1] = 1'b1;  exp_who[2] = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("rst_gnt", {6'b0, gnt1, gnt0}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_res", res, 8'h00);
        chk("rst_z", {7'b0, zflag}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Compact of zero: gnt after 1 edge, done after 3
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h00;
        @(negedge clk);
        chk("z_gnt0", {7'b0, gnt0}, 8'h01);
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        chk("z_done0", {7'b0, done0}, 8'h01);
        chk("z_res", res, 8'h00);
        chk("z_zflag", {7'b0, zflag}, 8'h01);
        @(negedge clk);

        // Extend A7 -> 07, zflag untouched
        req1 = 1'b1; op1 = 1'b1; data1 = 8'hA7;
        wait_done(1'b1, "ext");
        req1 = 1'b0;
        chk("ext_res", res, 8'h07);
        chk("ext_zflag", {7'b0, zflag}, 8'h01);
        @(negedge clk);

        // Both requesting continuously: 0,1,0
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h10;
        req1 = 1'b1; op1 = 1'b1; data1 = 8'h0C;
        for (int i = 0; i < 3; i++) begin
            wait_any(w, r);
            chk($sformatf("rr_who%0d", i), {7'b0, w}, {7'b0, exp_who[i]});
            chk($sformatf("rr_res%0d", i), r, exp_res[i]);
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr_zflag", {7'b0, zflag}, 8'h00);
        @(negedge clk);

        // Operand change after grant is ignored
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h00;
        @(negedge clk);
        chk("lat_gnt0", {7'b0, gnt0}, 8'h01);
        data0 = 8'hFF;
        wait_done(1'b0, "lat");
        req0 = 1'b0;
        chk("lat_res", res, 8'h00);
        chk("lat_zflag", {7'b0, zflag}, 8'h01);
        @(negedge clk);

        // Request dropped in EXEC still completes
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h55;
        @(negedge clk);
        req0 = 1'b0;
        wait_done(1'b0, "drop");
        @(negedge clk);
        chk("drop_done0", {7'b0, done0}, 8'h00);
        chk("drop_gnt0", {7'b0, gnt0}, 8'h00);
        chk("drop_busy", {7'b0, busy}, 8'h00);
        chk("drop_res", res, 8'h01);

        // Reset during EXEC aborts
        req1 = 1'b1; op1 = 1'b1; data1 = 8'h3C;
        @(negedge clk);
        chk("ab_gnt1", {7'b0, gnt1}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("ab_gnt1_rst", {7'b0, gnt1}, 8'h00);
        chk("ab_busy", {7'b0, busy}, 8'h00);
        chk("ab_res", res, 8'h00);
        chk("ab_zflag", {7'b0, zflag}, 8'h00);
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_done1", {7'b0, done1}, 8'h00);
        rst_n = 1'b1;
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h00;
        req1 = 1'b1; op1 = 1'b1; data1 = 8'hFF;
        @(negedge clk);
        chk("ab_prio", {6'b0, gnt1, gnt0}, 8'h01);
        wait_done(1'b0, "ab_op0");
        req0 = 1'b0;
        wait_done(1'b1, "ab_op1");
        req1 = 1'b0;
        chk("ab_res1", res, 8'h0F);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
